axi_sram_read_slave: RTL and testbench

- AXI read-channel responder at the slave end of the interconnect read path.
- Accepts one AR request at a time on the 8-bit slave-side ID.
- Reads the burst word-by-word from a single-port synchronous SRAM and returns R beats with RID echoed and RLAST on the final beat.
- Pairs with the interconnect read arbiter as slave S0/S1 for instruction/data memory.

---
 rtl/axi_sram_read_slave.sv | 136 +++++++++++++
 tb/tb_axi_sram_read_slave.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_read_slave.sv
// AXI read-channel slave that serves bursts from a single-port synchronous SRAM, two cycles per beat.
// Define AXI_SRAM_RANGE_CHK_EN to answer addresses beyond the SRAM with SLVERR instead of aliasing.
module axi_sram_read_slave #(
    parameter int IDS_W  = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4,
    parameter int MEM_AW = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDS_W-1:0]  ARID,
    input  logic [ADDR_W-1:0] ARADDR,
    input  logic [LEN_W-1:0]  ARLEN,
    input  logic [2:0]        ARSIZE,
    input  logic [1:0]        ARBURST,
    input  logic              ARVALID,
    output logic              ARREADY,
    output logic [IDS_W-1:0]  RID,
    output logic [DATA_W-1:0] RDATA,
    output logic [1:0]        RRESP,
    output logic              RLAST,
    output logic              RVALID,
    input  logic              RREADY,
    output logic              mem_en,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_FETCH    = 2'd1;
    localparam logic [1:0] ST_RESP     = 2'd2;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [1:0]        state;
    logic [1:0]        next_state;
    logic              arready_q;
    logic [IDS_W-1:0]  id_q;
    logic [MEM_AW-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  beat_cnt;
    logic [1:0]        burst_q;
    logic              err_q;
    logic              ar_hs;
    logic              last_beat;
    logic              addr_err;
    logic              unused_ar_bits;

`ifdef AXI_SRAM_RANGE_CHK_EN
    assign addr_err = |ARADDR[ADDR_W-1:MEM_AW+2];
`else
    assign addr_err = 1'b0;
`endif

    // The SRAM is word-wide, so byte offset and ARSIZE never change what is read.
    assign unused_ar_bits = ^{ARSIZE, ARADDR[1:0], ARADDR[ADDR_W-1:MEM_AW+2]};

    assign ar_hs     = ARVALID && arready_q;
    assign last_beat = (beat_cnt == len_q);

    // NOTE: next_state is assigned a default first so no path through always_comb infers a latch.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (ar_hs) begin
                    next_state = addr_err ? ST_RESP : ST_FETCH;
                end
            end
            ST_FETCH: begin
                next_state = ST_RESP;
            end
            ST_RESP: begin
                if (RREADY) begin
                    if (last_beat) begin
                        next_state = ST_IDLE;
                    end else if (err_q) begin
                        next_state = ST_RESP;
                    end else begin
                        next_state = ST_FETCH;
                    end
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // NOTE: non-blocking assignments make every flop sample pre-edge values together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            arready_q <= 1'b0;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            burst_q   <= '0;
            beat_cnt  <= '0;
            err_q     <= 1'b0;
        end else begin
            state     <= next_state;
            arready_q <= (next_state == ST_IDLE);
            if (ar_hs) begin
                id_q     <= ARID;
                addr_q   <= ARADDR[MEM_AW+1:2];
                len_q    <= ARLEN;
                burst_q  <= ARBURST;
                beat_cnt <= '0;
                err_q    <= addr_err;
            end else if ((state == ST_RESP) && RREADY && !last_beat) begin
                beat_cnt <= beat_cnt + LEN_W'(1);
                // WRAP is served as INCR; the word address rolls over at the top of the SRAM.
                if (burst_q != BURST_FIXED) begin
                    addr_q <= addr_q + MEM_AW'(1);
                end
            end
        end
    end

    // R outputs are decoded from held state, so they stay stable while the master stalls.
    always_comb begin
        RVALID = (state == ST_RESP);
        RLAST  = RVALID && last_beat;
        RID    = RVALID ? id_q : '0;
        RDATA  = (RVALID && !err_q) ? mem_rdata : '0;
        RRESP  = (RVALID && err_q) ? RESP_SLVERR : RESP_OKAY;
    end

    assign ARREADY  = arready_q;
    assign mem_en   = (state == ST_FETCH);
    assign mem_addr = addr_q;

endmodule

// File: tb/tb_axi_sram_read_slave.sv
// Scoreboard bench for axi_sram_read_slave: directed plan cases plus randomized bursts against a burst-level model.
module tb_axi_sram_read_slave;

    localparam int IDS_W  = 8;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 4;
    localparam int MEM_AW = 14;
    localparam int DEPTH  = 1 << MEM_AW;

    typedef struct {
        logic [IDS_W-1:0]  id;
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [IDS_W-1:0]  ARID = '0;
    logic [ADDR_W-1:0] ARADDR = '0;
    logic [LEN_W-1:0]  ARLEN = '0;
    logic [2:0]        ARSIZE = 3'd2;
    logic [1:0]        ARBURST = 2'b01;
    logic              ARVALID = 1'b0;
    logic              ARREADY;
    logic [IDS_W-1:0]  RID;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RLAST;
    logic              RVALID;
    logic              RREADY = 1'b1;
    logic              mem_en;
    logic [MEM_AW-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata = '0;

    logic [DATA_W-1:0] mem [DEPTH];
    beat_t             exp_q[$];
    int unsigned       exp_addr_q[$];
    int                beat_cyc[$];
    int                n_checks = 0;
    int                n_fail = 0;
    int                accepted = 0;
    int                cycle = 0;
    int                rr_mode = 0;

    axi_sram_read_slave #(
        .IDS_W (IDS_W),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .LEN_W (LEN_W),
        .MEM_AW(MEM_AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ARID     (ARID),
        .ARADDR   (ARADDR),
        .ARLEN    (ARLEN),
        .ARSIZE   (ARSIZE),
        .ARBURST  (ARBURST),
        .ARVALID  (ARVALID),
        .ARREADY  (ARREADY),
        .RID      (RID),
        .RDATA    (RDATA),
        .RRESP    (RRESP),
        .RLAST    (RLAST),
        .RVALID   (RVALID),
        .RREADY   (RREADY),
        .mem_en   (mem_en),
        .mem_addr (mem_addr),
        .mem_rdata(mem_rdata)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cycle++;
    end

    // Synchronous SRAM: data appears the cycle after mem_en and holds until the next read.
    always @(posedge clk) begin
        if (mem_en) mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_event(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: actual=none required=event at t=%0t", name, $time);
    endtask

    // Burst-level reference: one expected beat per ARLEN+1, word addresses from plain arithmetic.
    function automatic bit model(input logic [7:0] id, input logic [31:0] addr,
                                 input logic [3:0] len, input logic [1:0] burst);
        bit          err;
        int unsigned base;
        int unsigned word;
        beat_t       b;
        err = 1'b0;
`ifdef AXI_SRAM_RANGE_CHK_EN
        err = ((addr >> (MEM_AW + 2)) != 0);
`endif
        base = (addr >> 2) % DEPTH;
        for (int i = 0; i <= int'(len); i++) begin
            word   = (burst == 2'b00) ? base : (base + i) % DEPTH;
            b.id   = id;
            b.data = err ? '0 : mem[word];
            b.resp = err ? 2'b10 : 2'b00;
            b.last = (i == int'(len));
            exp_q.push_back(b);
            if (!err) exp_addr_q.push_back(word);
        end
        return err;
    endfunction

    // RREADY policy: 0 = always high, 1 = random, 2 = driven by the test sequence.
    initial forever begin
        @(posedge clk);
        #1;
        if (rr_mode == 0) RREADY = 1'b1;
        else if (rr_mode == 1) RREADY = ($urandom_range(0, 3) != 0);
    end

    // Monitor: pops the scoreboard on every accepted beat and every SRAM read.
    initial begin
        beat_t       e;
        bit          held;
        logic [43:0] held_v;
        held = 1'b0;
        held_v = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 1'b0;
            end else begin
                if (mem_en) begin
                    check("mem_en_while_rvalid", 64'(RVALID), 64'd0);
                    if (exp_addr_q.size() == 0) fail_event("mem_en_unexpected");
                    else check("mem_addr", 64'(mem_addr), 64'(exp_addr_q.pop_front()));
                end
                if (held) check("r_hold_stable", 64'({RVALID, RLAST, RID, RRESP, RDATA}), 64'(held_v));
                if (RVALID && RREADY) begin
                    held = 1'b0;
                    accepted++;
                    beat_cyc.push_back(cycle);
                    if (exp_q.size() == 0) begin
                        fail_event("rbeat_unexpected");
                    end else begin
                        e = exp_q.pop_front();
                        check("rid", 64'(RID), 64'(e.id));
                        check("rdata", 64'(RDATA), 64'(e.data));
                        check("rresp", 64'(RRESP), 64'(e.resp));
                        check("rlast", 64'(RLAST), 64'(e.last));
                    end
                end else if (RVALID) begin
                    held = 1'b1;
                    held_v = {RVALID, RLAST, RID, RRESP, RDATA};
                end else begin
                    held = 1'b0;
                end
            end
        end
    end

    task automatic do_burst(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [1:0] burst, output bit err);
        bit hs;
        int n;
        @(posedge clk);
        #1;
        err = model(id, addr, len, burst);
        beat_cyc.delete();
        ARID = id;
        ARADDR = addr;
        ARLEN = len;
        ARBURST = burst;
        ARSIZE = 3'($urandom_range(0, 7));
        ARVALID = 1'b1;
        hs = 1'b0;
        n = 0;
        while (!hs) begin
            @(negedge clk);
            hs = ARREADY;
            @(posedge clk);
            n++;
            if (!hs && n > 400) begin
                fail_event("ar_handshake_timeout");
                break;
            end
        end
        #1 ARVALID = 1'b0;
    endtask

    task automatic wait_done(input bit gap_chk, input int nbeats, input int gap);
        int  n;
        bit  timed_out;
        n = 0;
        timed_out = 1'b0;
        while (exp_q.size() != 0) begin
            @(posedge clk);
            n++;
            if (n > 600) begin
                fail_event("burst_done_timeout");
                exp_q.delete();
                exp_addr_q.delete();
                timed_out = 1'b1;
                break;
            end
        end
        if (!timed_out) begin
            @(negedge clk);
            check("arready_after_last", 64'(ARREADY), 64'd1);
            check("no_stray_mem_read", 64'(exp_addr_q.size()), 64'd0);
        end
        if (gap_chk) begin
            check("beat_count", 64'(beat_cyc.size()), 64'(nbeats));
            for (int i = 1; i < beat_cyc.size(); i++)
                check("beat_spacing", 64'(beat_cyc[i] - beat_cyc[i-1]), 64'(gap));
        end
    endtask

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: actual=60000 cycles required=completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit err;
        int acc0;
        int n;
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        mem[4] = 32'hDEAD_BEEF;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 64'({ARREADY, RVALID, RLAST, mem_en, RID, RRESP, RDATA, mem_addr}), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("arready_release_cycle", 64'(ARREADY), 64'd0);
        @(negedge clk);
        check("arready_after_reset", 64'(ARREADY), 64'd1);

        // Single beat with cycle-exact timing.
        do_burst(8'h05, 32'h0000_0010, 4'd0, 2'b01, err);
        @(negedge clk);
        check("single_fetch", 64'({mem_en, RVALID, mem_addr}), 64'({1'b1, 1'b0, 14'd4}));
        @(negedge clk);
        check("single_resp", 64'({RVALID, RLAST, mem_en}), 64'({1'b1, 1'b1, 1'b0}));
        wait_done(1'b1, 1, 2);

        do_burst(8'h11, 32'h0000_0100, 4'd3, 2'b01, err);
        wait_done(1'b1, 4, 2);

        // Backpressure on beat 2: RREADY low through its fetch and three RESP cycles.
        rr_mode = 2;
        acc0 = accepted;
        do_burst(8'h22, 32'h0000_0100, 4'd3, 2'b01, err);
        n = 0;
        while (accepted != acc0 + 1 && n < 50) begin
            @(posedge clk);
            n++;
        end
        if (accepted != acc0 + 1) fail_event("bp_first_beat");
        #1 RREADY = 1'b0;
        repeat (4) @(posedge clk);
        #1 RREADY = 1'b1;
        wait_done(1'b0, 0, 0);
        check("bp_beats_total", 64'(accepted - acc0), 64'd4);
        rr_mode = 0;

        do_burst(8'h33, 32'h0000_0200, 4'd2, 2'b00, err);
        wait_done(1'b1, 3, 2);
        do_burst(8'h44, 32'h0000_FFFC, 4'd1, 2'b01, err);
        wait_done(1'b1, 2, 2);
        do_burst(8'h55, 32'h0001_0000, 4'd1, 2'b01, err);
        wait_done(1'b1, 2, err ? 1 : 2);

        // Reset while beat 2 of an 8-beat burst is presented.
        rr_mode = 2;
        acc0 = accepted;
        do_burst(8'h66, 32'h0000_0040, 4'd7, 2'b01, err);
        n = 0;
        while (accepted != acc0 + 1 && n < 50) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        check("rst_beat2_presented", 64'(RVALID), 64'd1);
        rst = 1'b1;
        RREADY = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        exp_addr_q.delete();
        @(negedge clk);
        check("midburst_reset_outputs", 64'({ARREADY, RVALID, RLAST, mem_en, RID, RRESP, RDATA, mem_addr}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        RREADY = 1'b1;
        rr_mode = 0;
        @(negedge clk);
        check("midburst_arready_release", 64'(ARREADY), 64'd0);
        @(negedge clk);
        check("midburst_arready_back", 64'(ARREADY), 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("midburst_quiet", 64'({RVALID, mem_en}), 64'd0);
        end
        check("midburst_no_beats", 64'(accepted - acc0), 64'd1);

        // Random bursts, random backpressure, some issued while the previous burst is still running.
        rr_mode = 1;
        for (int k = 0; k < 24; k++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 7) != 0) a = a & 32'h0000_FFFF;
            do_burst(8'($urandom), a, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 2)), err);
            if (k == 23 || $urandom_range(0, 1) == 1) wait_done(1'b0, 0, 0);
        end
        rr_mode = 0;

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
